// File: rtl/board_controller_pkg.sv
// rtl/board_controller_pkg.sv - cell encodings and FSM state constants shared with the detector and benches
package board_controller_pkg;

  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [1:0] PLAYER_X = 2'b01;
  localparam logic [1:0] PLAYER_O = 2'b10;

  localparam logic [1:0] ST_PLAY  = 2'b00;
  localparam logic [1:0] ST_CHECK = 2'b01;
  localparam logic [1:0] ST_OVER  = 2'b10;

  localparam int NUM_CELLS = 9;

  function automatic logic [1:0] next_player(input logic [1:0] p);
    return (p == PLAYER_X) ? PLAYER_O : PLAYER_X;
  endfunction

endpackage

// File: rtl/board_controller.sv
// rtl/board_controller.sv - tic-tac-toe board: accepts moves, waits one cycle for the external
// winner detector, then either hands the turn over or ends the game.
module board_controller
  import board_controller_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic       win,
  input  logic [1:0] who,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] turn,
  output logic       move_ok,
  output logic       move_err,
  output logic       game_over,
  output logic       draw,
  output logic [1:0] winner,
  output logic [3:0] move_count
);

  logic [1:0] r_cells [NUM_CELLS];
  logic [1:0] r_state;
  logic [1:0] r_turn;
  logic [1:0] r_winner;
  logic [3:0] r_count;
  logic       r_draw;
  logic       r_move_ok;
  logic       r_move_err;

  logic       w_target_empty;
  logic       w_accept;

  // Out-of-range positions match no cell, so they read as "not empty" and get rejected.
  always_comb begin
    w_target_empty = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (move_pos == 4'(i + 1)) begin
        w_target_empty = (r_cells[i] == EMPTY);
      end
    end
  end

  assign w_accept = (r_state == ST_PLAY) && move_valid && w_target_empty;

  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        r_cells[i] <= EMPTY;
      end
      r_state    <= ST_PLAY;
      r_turn     <= FIRST_PLAYER;
      r_winner   <= EMPTY;
      r_count    <= 4'd0;
      r_draw     <= 1'b0;
      r_move_ok  <= 1'b0;
      r_move_err <= 1'b0;
    end else begin
      r_move_ok  <= w_accept;
      r_move_err <= move_valid && !w_accept;
      case (r_state)
        ST_PLAY: begin
          if (w_accept) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
              if (move_pos == 4'(i + 1)) begin
                r_cells[i] <= r_turn;
              end
            end
            r_count <= r_count + 4'd1;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Win is checked first so a line completed by the ninth move is not a draw.
          if (win) begin
            r_winner <= who;
            r_draw   <= 1'b0;
            r_state  <= ST_OVER;
          end else if (r_count == 4'd9) begin
            r_winner <= EMPTY;
            r_draw   <= 1'b1;
            r_state  <= ST_OVER;
          end else begin
            r_turn  <= next_player(r_turn);
            r_state <= ST_PLAY;
          end
        end
        ST_OVER: begin
          r_state <= ST_OVER;
        end
        default: begin
          r_state <= ST_PLAY;
        end
      endcase
    end
  end

  assign pos1       = r_cells[0];
  assign pos2       = r_cells[1];
  assign pos3       = r_cells[2];
  assign pos4       = r_cells[3];
  assign pos5       = r_cells[4];
  assign pos6       = r_cells[5];
  assign pos7       = r_cells[6];
  assign pos8       = r_cells[7];
  assign pos9       = r_cells[8];
  assign turn       = r_turn;
  assign move_ok    = r_move_ok;
  assign move_err   = r_move_err;
  assign game_over  = (r_state == ST_OVER);
  assign draw       = r_draw;
  assign winner     = r_winner;
  assign move_count = r_count;

endmodule
